// File: rtl/dma_copy_engine.sv
// dma_copy_engine: second bus master that copies a block of 32-bit words, ascending, two cycles per word
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   start               : request pulse, accepted only in IDLE
//   src_addr, dst_addr  : first source / destination word address, latched on accept
//   length              : word count 0..96, latched on accept
//   busy, done, error   : bus-owned flag, one-cycle completion pulse, parameter-check failure
//   mem_address/wdata/we: drive the memory controller; mem_rdata is its combinational read data
module dma_copy_engine #(
    parameter logic [15:0] MAP_TOP = 16'h005F,
    parameter logic [15:0] WR_BASE = 16'h0020
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] src_addr,
    input  logic [15:0] dst_addr,
    input  logic [6:0]  length,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] mem_address,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
    state_t      r_state, w_next;
    logic [15:0] r_src, r_dst;
    logic [6:0]  r_len, r_i;
    logic [31:0] r_buf;
    logic        r_error;
    logic [16:0] w_src_end, w_dst_end;
    logic        w_bad, w_last;
    // 17-bit end addresses so a block running past 16'hFFFF cannot wrap into the map
    assign w_src_end = {1'b0, src_addr} + {10'd0, length} - 17'd1;
    assign w_dst_end = {1'b0, dst_addr} + {10'd0, length} - 17'd1;
    assign w_bad     = (w_src_end > {1'b0, MAP_TOP}) || (dst_addr < WR_BASE) || (w_dst_end > {1'b0, MAP_TOP});
    assign w_last    = (r_i + 7'd1) == r_len;
    assign error     = r_error;
    always_ff @(posedge clock) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end
    always_comb begin
        w_next      = r_state;
        busy        = (r_state == READ) || (r_state == WRITE);
        done        = r_state == DONE;
        mem_we      = r_state == WRITE;
        mem_wdata   = (r_state == WRITE) ? r_buf : 32'd0;
        mem_address = (r_state == READ)  ? r_src + {9'd0, r_i} :
                      (r_state == WRITE) ? r_dst + {9'd0, r_i} : 16'd0;
        case (r_state)
            IDLE:    w_next = !start ? IDLE : ((length == 7'd0) || w_bad) ? DONE : READ;
            READ:    w_next = WRITE;
            WRITE:   w_next = w_last ? DONE : READ;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            r_src   <= '0;
            r_dst   <= '0;
            r_len   <= '0;
            r_i     <= '0;
            r_buf   <= '0;
            r_error <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_src   <= src_addr;
                    r_dst   <= dst_addr;
                    r_len   <= length;
                    r_i     <= '0;
                    // a zero-length request never fails the range check
                    r_error <= (length != 7'd0) && w_bad;
                end
                READ:    r_buf <= mem_rdata;
                WRITE:   r_i <= r_i + 7'd1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dma_copy_engine.sv
// tb_dma_copy_engine: randomized and directed bench for dma_copy_engine against a cycle-schedule model
module tb_dma_copy_engine;
    logic        clock, reset, start;
    logic [15:0] src_addr, dst_addr;
    logic [6:0]  length;
    logic        busy, done, error, mem_we;
    logic [15:0] mem_address;
    logic [31:0] mem_wdata, mem_rdata;
    typedef struct packed {
        logic        busy;
        logic        done;
        logic        err;
        logic        we;
        logic [15:0] addr;
        logic [31:0] wdata;
    } ent_t;
    ent_t        q[$];
    ent_t        ce;
    logic        exp_err;
    logic [31:0] mem [128];
    logic [31:0] rm [128];
    logic        ld_en;
    logic [6:0]  ld_addr;
    logic [31:0] ld_data;
    int          errors, checks;
    dma_copy_engine dut (
        .clock(clock), .reset(reset), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
        .busy(busy), .done(done), .error(error),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata)
    );
    initial clock = 1'b0;
    always #5 clock = ~clock;
    assign mem_rdata = (mem_address <= 16'h005F) ? mem[mem_address[6:0]] : 32'h0;
    always @(posedge clock) begin
        if (ld_en)
            mem[ld_addr] <= ld_data;
        else if (mem_we && mem_address <= 16'h005F)
            mem[mem_address[6:0]] <= mem_wdata;
    end
    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    always @(negedge clock) begin
        if (reset) begin
            q.delete();
            exp_err = 1'b0;
            ce = '0;
        end else if (q.size() > 0) begin
            ce = q.pop_front();
            exp_err = ce.err;
        end else begin
            ce = '0;
            ce.err = exp_err;
        end
        chk({busy, done, error, mem_we, mem_address, mem_wdata} === ce, "outputs",
            {10'd0, busy, done, error, mem_we, mem_address, mem_wdata}, {10'd0, ce});
    end
    function automatic bit is_bad(int s, int d, int l);
        return l != 0 && (s + l - 1 > 95 || d < 32 || d + l - 1 > 95);
    endfunction
    task automatic push(input int s, input int d, input int l, input int ncommit);
        logic [31:0] tmp [128];
        logic [31:0] v;
        ent_t e;
        if (l == 0 || is_bad(s, d, l)) begin
            e = '0; e.done = 1'b1; e.err = is_bad(s, d, l);
            q.push_back(e);
            return;
        end
        tmp = rm;
        for (int k = 0; k < l; k++) begin
            v = tmp[s + k];
            e = '0; e.busy = 1'b1; e.addr = 16'(s + k);
            q.push_back(e);
            e.we = 1'b1; e.addr = 16'(d + k); e.wdata = v;
            q.push_back(e);
            tmp[d + k] = v;
            if (k < ncommit) rm[d + k] = v;
        end
        e = '0; e.done = 1'b1;
        q.push_back(e);
    endtask
    task automatic push_idle(input bit err);
        ent_t e;
        e = '0; e.err = err;
        q.push_back(e);
    endtask
    task automatic load(input int a, input logic [31:0] d);
        ld_en = 1'b1; ld_addr = 7'(a); ld_data = d;
        @(negedge clock); #1;
        ld_en = 1'b0;
        rm[a] = d;
    endtask
    task automatic set_req(input int s, input int d, input int l);
        src_addr = 16'(s); dst_addr = 16'(d); length = 7'(l);
    endtask
    task automatic wait_done(output int n, output int nb);
        n = 1; nb = 0;
        while (!done && n < 300) begin
            if (busy) nb++;
            @(negedge clock); #1;
            n++;
        end
    endtask
    task automatic mem_check(input string name);
        int bad;
        bad = 0;
        for (int a = 0; a < 96; a++)
            if (mem[a] !== rm[a]) bad++;
        chk(bad == 0, name, 64'(bad), 64'd0);
    endtask
    task automatic run(input int s, input int d, input int l, output int n, output int nb, output bit err);
        int en;
        push(s, d, l, l);
        set_req(s, d, l); start = 1'b1;
        @(negedge clock); #1;
        start = 1'b0;
        wait_done(n, nb);
        err = error;
        en = (l == 0 || is_bad(s, d, l)) ? 1 : 2 * l + 1;
        chk(n == en, "done_latency", 64'(n), 64'(en));
        chk(nb == en - 1, "busy_cycles", 64'(nb), 64'(en - 1));
        @(negedge clock); #1;
        mem_check("memory");
    endtask
    initial begin
        int n, nb, n2, nb2, s, d, l;
        bit err;
        errors = 0; checks = 0;
        reset = 1'b1; start = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        set_req(0, 0, 0);
        @(negedge clock); #1;
        for (int a = 0; a < 96; a++) load(a, $urandom);
        reset = 1'b0;
        @(negedge clock); #1;
        load(16'h40, 32'hA000_000A); load(16'h41, 32'hB000_000B);
        load(16'h42, 32'hC000_000C); load(16'h43, 32'hD000_000D);
        run(16'h40, 16'h50, 4, n, nb, err);
        chk(n == 9, "ram_done_9", 64'(n), 64'd9);
        chk(nb == 8, "ram_busy_8", 64'(nb), 64'd8);
        chk(err == 1'b0, "ram_error", 64'(err), 64'd0);
        chk(mem[16'h50] === 32'hA000_000A, "ram_w0", 64'(mem[16'h50]), 64'hA000_000A);
        chk(mem[16'h53] === 32'hD000_000D, "ram_w3", 64'(mem[16'h53]), 64'hD000_000D);
        run(16'h00, 16'h20, 32, n, nb, err);
        chk(n == 65, "rom_io_done", 64'(n), 64'd65);
        run(16'h00, 16'h10, 1, n, nb, err);
        chk(n == 1 && err == 1'b1, "illegal_dst", {32'(n), 31'd0, err}, {32'd1, 32'd1});
        chk(error == 1'b1, "error_held", 64'(error), 64'd1);
        run(16'h5E, 16'h40, 3, n, nb, err);
        chk(n == 1 && err == 1'b1, "illegal_src", {32'(n), 31'd0, err}, {32'd1, 32'd1});
        run(16'h5F, 16'h5F, 1, n, nb, err);
        chk(n == 3 && err == 1'b0, "edge_valid", {32'(n), 31'd0, err}, {32'd3, 32'd0});
        run(16'h00, 16'h30, 0, n, nb, err);
        chk(n == 1 && err == 1'b0, "zero_len", {32'(n), 31'd0, err}, {32'd1, 32'd0});
        load(16'h40, 32'h1111_1111); load(16'h41, 32'h2222_2222); load(16'h42, 32'h3333_3333);
        run(16'h40, 16'h41, 2, n, nb, err);
        chk(mem[16'h41] === 32'h1111_1111, "overlap_41", 64'(mem[16'h41]), 64'h1111_1111);
        chk(mem[16'h42] === 32'h1111_1111, "overlap_42", 64'(mem[16'h42]), 64'h1111_1111);
        push(16'h40, 16'h50, 8, 3);
        set_req(16'h40, 16'h50, 8); start = 1'b1;
        @(negedge clock); #1;
        start = 1'b0;
        repeat (5) begin @(negedge clock); #1; end
        reset = 1'b1;
        @(negedge clock); #1;
        reset = 1'b0;
        repeat (3) begin @(negedge clock); #1; end
        mem_check("reset_memory");
        run(16'h44, 16'h48, 3, n, nb, err);
        push(16'h44, 16'h58, 3, 3);
        push_idle(1'b0);
        push(16'h58, 16'h30, 4, 4);
        set_req(16'h44, 16'h58, 3); start = 1'b1;
        @(negedge clock); #1;
        set_req(16'h58, 16'h30, 4);
        wait_done(n, nb);
        @(negedge clock); #1;
        @(negedge clock); #1;
        start = 1'b0;
        wait_done(n2, nb2);
        chk(n == 7 && n2 == 9, "back_to_back", {32'(n), 32'(n2)}, {32'd7, 32'd9});
        @(negedge clock); #1;
        mem_check("b2b_memory");
        for (int t = 0; t < 30; t++) begin
            s = $urandom_range(0, 95);
            d = $urandom_range(0, 95);
            l = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 96) : $urandom_range(0, 12);
            run(s, d, l, n, nb, err);
            chk(err == is_bad(s, d, l), "rand_error", 64'(err), 64'(is_bad(s, d, l)));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
